// File: rtl/video_pkg.sv
// Shared video definitions: writer FSM states and test-pattern colours.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        PAUSE
    } wr_state_t;

    localparam logic [31:0] WHITE = 32'h00FF_FFFF;
    localparam logic [31:0] BLACK = 32'h0000_0000;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/mire_writer_if.sv
// Wishbone classic write-master bus used by the test-pattern writer.
interface mire_writer_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty
    );

endinterface

// File: rtl/mire_writer.sv
// Writes a grid test pattern into the framebuffer, one Wishbone single write per pixel,
// in raster order, releasing the bus for one cycle after every burst.
module mire_writer
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           en,
    output logic           frame_done,
    mire_writer_if.master  wb
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int BW = $clog2(BURST);
    localparam int IW = $clog2(HDISP * VDISP);

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

    wr_state_t     state;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [BW-1:0] bcnt;
    logic [31:0]   dat;
    logic          cyc, stb;
    logic          last_px, burst_end;

    // Grid line every 16 pixels horizontally and vertically.
    function automatic logic [31:0] pattern(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic [31:0] xe, ye;
        xe = 32'(px);
        ye = 32'(py);
        return (xe[3:0] == 4'd0 || ye[3:0] == 4'd0) ? WHITE : BLACK;
    endfunction

    assign last_px   = (x == X_LAST) && (y == Y_LAST);
    assign burst_end = (bcnt == B_LAST);

    always_comb begin
        x_nxt   = x + 1'b1;
        y_nxt   = y;
        idx_nxt = last_px ? '0 : idx + 1'b1;
        if (x == X_LAST) begin
            x_nxt = '0;
            y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    // NOTE: every register, outputs included, is cleared by the asynchronous reset so the
    // bus is released the instant sys_rst rises, without waiting for a clock edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            idx        <= '0;
            bcnt       <= '0;
            dat        <= WHITE;
            cyc        <= 1'b0;
            stb        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= WRITE;
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                    end
                end
                WRITE: begin
                    // A faulted access (err/rty, even alongside ack) is retried after a pause.
                    if (wb.err || wb.rty) begin
                        state <= PAUSE;
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                    end else if (wb.ack) begin
                        x   <= x_nxt;
                        y   <= y_nxt;
                        idx <= idx_nxt;
                        dat <= pattern(x_nxt, y_nxt);
                        if (burst_end || last_px) begin
                            state      <= PAUSE;
                            cyc        <= 1'b0;
                            stb        <= 1'b0;
                            bcnt       <= '0;
                            frame_done <= last_px;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    state <= en ? WRITE : IDLE;
                    cyc   <= en;
                    stb   <= en;
                end
                default: begin
                    state <= IDLE;
                    cyc   <= 1'b0;
                    stb   <= 1'b0;
                end
            endcase
        end
    end

    assign wb.cyc    = cyc;
    assign wb.stb    = stb;
    assign wb.we     = 1'b1;
    assign wb.adr    = 32'(idx) << 2;
    assign wb.dat_ms = dat;
    assign wb.sel    = 4'hF;
    assign wb.cti    = CTI_CLASSIC;
    assign wb.bte    = BTE_LINEAR;

endmodule

// File: tb/tb_mire_writer.sv
// Scoreboard bench for mire_writer: a randomised Wishbone slave pushes the expected pixel
// on every ack, and an independent monitor pops and compares against the DUT.
module tb_mire_writer;

    localparam int HDISP = 32;
    localparam int VDISP = 4;
    localparam int BURST = 8;
    localparam int NPIX  = HDISP * VDISP;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        bit          last;
    } txn_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic en      = 1'b0;
    logic frame_done;

    mire_writer_if wb();

    mire_writer #(.HDISP(HDISP), .VDISP(VDISP), .BURST(BURST)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .frame_done (frame_done),
        .wb         (wb)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    txn_t        exp_q[$];
    int unsigned model_pix = 0;

    int          wait_max    = 0;   // fixed wait states per access, -1 for random 0..2
    int          cur_wait    = 0;
    int          waited      = 0;
    bit          rand_err    = 1'b0;
    bit          err_pending = 1'b0;
    logic [31:0] err_adr     = '0;
    int          err_kind    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: bound expired at %0t", name, $time);
    endtask

    // Pixel n in raster order: address, grid colour, end-of-frame flag.
    function automatic txn_t model_txn(input int unsigned n);
        txn_t        t;
        int unsigned px, py;
        px     = n % HDISP;
        py     = n / HDISP;
        t.adr  = n * 4;
        t.dat  = (px % 16 == 0 || py % 16 == 0) ? 32'h00FF_FFFF : 32'h0000_0000;
        t.last = (n == NPIX - 1);
        return t;
    endfunction

    task automatic inject(input int kind);
        case (kind)
            0:       wb.err = 1'b1;
            1:       wb.rty = 1'b1;
            default: begin wb.ack = 1'b1; wb.err = 1'b1; end
        endcase
    endtask

    // Slave: responds on the falling edge so the DUT sees a settled response.
    initial begin : slave
        wb.ack = 1'b0;
        wb.err = 1'b0;
        wb.rty = 1'b0;
        forever begin
            @(negedge sys_clk);
            wb.ack = 1'b0;
            wb.err = 1'b0;
            wb.rty = 1'b0;
            if (sys_rst) begin
                model_pix = 0;
                waited    = 0;
                exp_q.delete();
            end else if (wb.cyc && wb.stb) begin
                if (waited < cur_wait) begin
                    waited++;
                end else begin
                    waited   = 0;
                    cur_wait = (wait_max < 0) ? int'($urandom_range(0, 2)) : wait_max;
                    if (err_pending && wb.adr == err_adr) begin
                        err_pending = 1'b0;
                        inject(err_kind);
                    end else if (rand_err && $urandom_range(0, 15) == 0) begin
                        inject(int'($urandom_range(0, 2)));
                    end else begin
                        wb.ack = 1'b1;
                        exp_q.push_back(model_txn(model_pix));
                        model_pix = (model_pix + 1) % NPIX;
                    end
                end
            end
        end
    end

    // Monitor: checks each cycle against what the previous cycle implies.
    initial begin : monitor
        bit          pv, p_cyc, p_en, p_ack, p_err, p_end, p_last;
        bit          cur_ack, cur_err, cur_end, cur_last, retry_pending;
        logic [31:0] p_adr, p_dat, retry_adr;
        int          mb;
        txn_t        t;
        pv = 1'b0;
        mb = 0;
        retry_pending = 1'b0;
        forever begin
            @(negedge sys_clk);
            #1;
            if (sys_rst) begin
                pv = 1'b0;
                mb = 0;
                retry_pending = 1'b0;
                continue;
            end
            if (pv) begin
                check("frame_done", 32'(frame_done), 32'(p_last));
                if (!p_cyc) begin
                    check("cyc_after_idle", 32'(wb.cyc), 32'(p_en));
                end else if (p_err) begin
                    check("cyc_after_err", 32'(wb.cyc), 32'd0);
                end else if (p_ack) begin
                    check("cyc_after_ack", 32'(wb.cyc), 32'(!p_end));
                end else begin
                    check("cyc_hold", 32'(wb.cyc), 32'd1);
                    check("adr_stable", wb.adr, p_adr);
                    check("dat_stable", wb.dat_ms, p_dat);
                end
            end
            if (wb.cyc) begin
                check("bus_ctl", 32'({wb.stb, wb.we, wb.sel, wb.cti, wb.bte}),
                      32'({1'b1, 1'b1, 4'hF, 3'b000, 2'b00}));
                if (retry_pending) begin
                    check("reissue_adr", wb.adr, retry_adr);
                    retry_pending = 1'b0;
                end
            end else begin
                check("stb_idle", 32'(wb.stb), 32'd0);
            end
            cur_err  = wb.cyc && (wb.err || wb.rty);
            cur_ack  = wb.cyc && wb.ack && !cur_err;
            cur_end  = 1'b0;
            cur_last = 1'b0;
            if (cur_ack) begin
                check("sb_depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    t = exp_q.pop_front();
                    check("adr", wb.adr, t.adr);
                    check("dat", wb.dat_ms, t.dat);
                    cur_last = t.last;
                end
                mb++;
                cur_end = (mb == BURST) || cur_last;
                if (cur_end) mb = 0;
            end
            if (cur_err) begin
                retry_pending = 1'b1;
                retry_adr     = wb.adr;
            end
            p_cyc  = wb.cyc;
            p_en   = en;
            p_ack  = cur_ack;
            p_err  = cur_err;
            p_end  = cur_end;
            p_last = cur_ack && cur_last;
            p_adr  = wb.adr;
            p_dat  = wb.dat_ms;
            pv     = 1'b1;
        end
    end

    task automatic wait_cyc(input logic want, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            #1;
            if (wb.cyc === want) return;
        end
        timeout(name);
    endtask

    logic [31:0] err_adrs[3]  = '{32'h0000_000C, 32'h0000_0040, 32'h0000_01FC};

    initial begin : control
        sys_rst = 1'b1;
        @(negedge sys_clk);
        #1;
        check("rst_cyc", 32'(wb.cyc), 32'd0);
        check("rst_adr", wb.adr, 32'd0);
        check("rst_dat", wb.dat_ms, 32'h00FF_FFFF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        #2;
        sys_rst = 1'b0;
        en      = 1'b1;

        // Zero-wait slave for a little over two frames.
        repeat (320) @(negedge sys_clk);

        // Three wait states on every access.
        wait_max = 3;
        repeat (150) @(negedge sys_clk);
        wait_max = 0;

        // Directed faults: err, retry, and ack+err on the last pixel of the frame.
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            err_adr     = err_adrs[k];
            err_kind    = k;
            err_pending = 1'b1;
            for (int i = 0; i < 400 && err_pending; i++) @(negedge sys_clk);
            check("fault_hit", 32'(err_pending), 32'd0);
            err_pending = 1'b0;
            repeat (20) @(negedge sys_clk);
        end

        // Random wait states and random faults.
        wait_max = -1;
        rand_err = 1'b1;
        repeat (800) @(negedge sys_clk);
        rand_err = 1'b0;
        wait_max = 0;

        // Drop en mid-burst: the burst completes, then the writer parks.
        wait_cyc(1'b0, 40, "pause_before_drop");
        wait_cyc(1'b1, 40, "burst_start");
        repeat (3) @(negedge sys_clk);
        en = 1'b0;
        wait_cyc(1'b0, 40, "idle_after_drop");
        repeat (20) @(negedge sys_clk);
        #1;
        check("parked_cyc", 32'(wb.cyc), 32'd0);

        // Resume, then reset in the middle of the next burst.
        @(negedge sys_clk);
        en = 1'b1;
        wait_cyc(1'b1, 10, "resume");
        repeat (4) @(negedge sys_clk);
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        check("midrst_cyc", 32'(wb.cyc), 32'd0);
        check("midrst_stb", 32'(wb.stb), 32'd0);
        check("midrst_adr", wb.adr, 32'd0);
        @(negedge sys_clk);
        #3;
        sys_rst = 1'b0;
        wait_cyc(1'b1, 10, "restart");
        check("restart_adr", wb.adr, 32'd0);
        check("restart_dat", wb.dat_ms, 32'h00FF_FFFF);

        repeat (60) @(negedge sys_clk);
        en = 1'b0;
        wait_cyc(1'b0, 40, "final_idle");
        repeat (3) @(negedge sys_clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mire_writer.md
MIRE_WRITER -- requirements
Module: mire_writer

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter BURST, default 64, max consecutive writes before bus release.
REQ-004 sys_clk  input  1  system clock (100 MHz); all logic on its rising edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  pattern writing enable (level).
REQ-007 cyc  output  1  Wishbone cycle.
REQ-008 stb  output  1  Wishbone strobe.
REQ-009 we  output  1  Wishbone write enable.
REQ-010 adr  output  32  Wishbone byte address.
REQ-011 dat_ms  output  32  Wishbone write data.
REQ-012 sel  output  4  byte selects.
REQ-013 cti  output  3  cycle type identifier.
REQ-014 bte  output  2  burst type extension.
REQ-015 ack  input  1  Wishbone acknowledge.
REQ-016 err  input  1  Wishbone error.
REQ-017 rty  input  1  Wishbone retry.
REQ-018 frame_done  output  1  one-cycle pulse on ack of last pixel of a frame.

Function
REQ-019 Block SHALL write a test pattern into the SDRAM framebuffer as classic single Wishbone writes, one 32-bit word per pixel, raster order.
REQ-020 Pixel (x,y) SHALL be at adr = 4*(y*HDISP + x); adr SHALL be kept as a running word index, incremented on ack, no multiplier.
REQ-021 dat_ms SHALL be 32'h00FFFFFF when x[3:0]==0 or y[3:0]==0, else 32'h00000000; dat_ms[31:24] always 0.
REQ-022 Constants: we=1 whenever cyc=1, sel=4'hF, cti=3'b000, bte=2'b00.
REQ-023 FSM states IDLE, WRITE, PAUSE.
REQ-024 IDLE: cyc=stb=0; go WRITE when en=1.
REQ-025 WRITE: cyc=stb=1; adr/dat_ms SHALL stay stable until ack.
REQ-026 On ack in WRITE: advance x (wrap HDISP-1 -> 0 with y+1), y wraps VDISP-1 -> 0 and index -> 0; burst counter +1.
REQ-027 After BURST-th ack of a burst, or ack of last pixel of frame, go PAUSE (cyc=stb=0 for exactly 1 cycle), burst counter cleared.
REQ-028 PAUSE -> WRITE if en=1, else IDLE.
REQ-029 en falling during WRITE SHALL NOT abort the pending access; FSM goes IDLE only at next burst boundary (PAUSE).
REQ-030 err or rty in WRITE SHALL NOT advance pixel or burst counter; block SHALL go PAUSE and re-issue same pixel afterwards.
REQ-031 ack together with err/rty SHALL be treated as err (no advance).
REQ-032 frame_done SHALL pulse high one cycle after the ack of pixel (HDISP-1,VDISP-1); writing then restarts at (0,0) with no gap beyond PAUSE.
REQ-033 Throughput: one pixel per ack; latency from ack to next stb with new adr = 1 cycle.

Reset
REQ-034 sys_rst SHALL asynchronously force: state IDLE, x=y=0, index=0, burst counter 0, cyc=stb=0, adr=0, dat_ms=32'h00FFFFFF, frame_done=0.
REQ-035 Reset mid-transfer SHALL drop cyc/stb immediately; writing restarts from (0,0).

Structure
REQ-036 FSM state enum and pattern colour constants (WHITE, BLACK) SHALL live in shared package video_pkg.
REQ-037 Single module; pattern function inline, no sub-module.
REQ-038 Counter widths SHALL be $clog2 of HDISP, VDISP, BURST and HDISP*VDISP.

Verification (HDISP=32, VDISP=4, BURST=8, slave acks every cycle)
REQ-039 Reset release, en=1 -> first stb at adr=0, dat=00FFFFFF; after 8 acks cyc=0 for 1 cycle, next adr=0x20.
REQ-040 Full frame -> adr 0..0x1FC sequence, frame_done pulse after ack at adr 0x1FC, next adr=0.
REQ-041 Pattern check -> (1,1) dat=0, (16,2) dat=00FFFFFF, (5,0) dat=00FFFFFF.
REQ-042 Slave inserts 3 wait cycles -> adr/dat_ms stable until ack; no skipped pixel.
REQ-043 err on pixel adr 0x0C -> PAUSE, then adr 0x0C re-issued, burst count unaffected.
REQ-044 en low at burst 2, sys_rst pulsed mid-burst 3 -> IDLE after burst 2 ends; after reset, first adr=0.
